// File: rtl/data_memory_responder.sv
// Memory-side responder for the CPU data-memory port: byte-lane RAM with
// read-first access, programmable wait states and a post-reset zeroing sweep.
module data_memory_responder #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  input  logic [3:0]            wbe,
  output logic [31:0]           rdata,
  output logic                  ack,
  output logic                  busy
);

  localparam int unsigned DEPTH  = 1 << ADDR_WIDTH;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned LANES  = 4;

  localparam logic [1:0] S_CLEAR = 2'd0;
  localparam logic [1:0] S_IDLE  = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_W-1:0]     word_q, word_d;
  logic                  ack_q, ack_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;

  logic [DATA_W-1:0]     mem_q [DEPTH];
  logic [LANES-1:0]      mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W-1:0]     rd_word;
  logic                  accept;

  assign busy    = (state_q == S_CLEAR) || (state_q == S_WAIT);
  assign accept  = req && !busy;
  assign rd_word = mem_q[addr];
  assign ack     = ack_q;
  assign rdata   = rdata_q;

  // Next-state, RAM write port and response latching
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    word_d    = word_q;
    ack_d     = 1'b0;
    rdata_d   = rdata_q;
    mem_we    = '0;
    mem_waddr = addr;
    mem_wdata = wdata;

    case (state_q)
      S_CLEAR: begin
        mem_we    = '1;
        mem_waddr = ptr_q;
        mem_wdata = '0;
        ptr_d     = ptr_q + ADDR_WIDTH'(1);
        if (ptr_q == ADDR_WIDTH'(DEPTH - 1)) begin
          state_d = S_IDLE;
        end
      end

      S_IDLE, S_RESP: begin
        if (accept) begin
          // Read-first: the response word is captured before the lane write lands
          mem_we = wbe;
          word_d = rd_word;
          if (WAIT_CYCLES == 0) begin
            state_d = S_RESP;
            ack_d   = 1'b1;
            rdata_d = rd_word;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_W'(WAIT_CYCLES - 1);
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_RESP;
          ack_d   = 1'b1;
          rdata_d = word_q;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      default: begin
        state_d = S_CLEAR;
        ptr_d   = '0;
      end
    endcase
  end

  // Control and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_CLEAR;
      ptr_q   <= '0;
      cnt_q   <= '0;
      word_q  <= '0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
    end
  end

  // Byte-lane RAM; writes suppressed while reset is asserted
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < LANES; i++) begin
        if (mem_we[i]) begin
          mem_q[mem_waddr][8*i +: 8] <= mem_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// Scoreboard bench: instance 0 runs with no wait states, instance 1 with three.
module tb_data_memory_responder;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic        clk;
  logic [1:0]  rst, req, ack, busy;
  logic [9:0]  addr  [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  logic [3:0]  wbe   [2];

  int   cyc = 0;
  int   total = 0;
  int   passed = 0;
  int   busy0_viol = 0;
  bit   sweep_done0 = 1'b0;
  exp_t q0[$];
  exp_t q1[$];

  data_memory_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst[0]), .req(req[0]), .addr(addr[0]), .wdata(wdata[0]),
    .wbe(wbe[0]), .rdata(rdata[0]), .ack(ack[0]), .busy(busy[0])
  );

  data_memory_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(3)) u_dut1 (
    .clk(clk), .rst(rst[1]), .req(req[1]), .addr(addr[1]), .wdata(wdata[1]),
    .wbe(wbe[1]), .rdata(rdata[1]), .ack(ack[1]), .busy(busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
  endtask

  function automatic int wait_of(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  // Monitor: pops one expectation per ack and flags late or spurious acks
  task automatic mon(input int d);
    exp_t e;
    bit   have;
    have = (d == 0) ? (q0.size() > 0) : (q1.size() > 0);
    if (have) e = (d == 0) ? q0[0] : q1[0];
    if (ack[d]) begin
      if (!have) begin
        check($sformatf("dut%0d_unexpected_ack", d), 32'(ack[d]), 32'd0);
      end else begin
        if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        check($sformatf("dut%0d_ack_rdata", d), rdata[d], e.data);
        check($sformatf("dut%0d_ack_cycle", d), 32'(cyc), 32'(e.cyc));
      end
    end else if (have && e.cyc < cyc) begin
      if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
      check($sformatf("dut%0d_missing_ack", d), 32'(ack[d]), 32'd1);
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) mon(d);
    if (sweep_done0 && rst[0] == 1'b0 && busy[0]) busy0_viol++;
  end

  // Present a request, hold it until accepted, and log the expected ack
  task automatic issue(input int d, input logic [9:0] a, input logic [31:0] wd,
                       input logic [3:0] be, input logic [31:0] exp_rd,
                       input bit track, output int acc_cyc);
    exp_t e;
    int   n;
    n = 0;
    req[d] = 1'b1; addr[d] = a; wdata[d] = wd; wbe[d] = be;
    forever begin
      @(negedge clk);
      if (!busy[d]) break;
      n++;
      if (n > 2000) begin
        check($sformatf("dut%0d_accept_timeout", d), 32'(busy[d]), 32'd0);
        break;
      end
    end
    acc_cyc = cyc;
    if (track) begin
      e.data = exp_rd;
      e.cyc  = cyc + 1 + wait_of(d);
      if (d == 0) q0.push_back(e); else q1.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int d);
    req[d] = 1'b0; wbe[d] = 4'h0;
  endtask

  // Count busy cycles of the zeroing sweep on the selected instances
  task automatic sweep(input bit [1:0] m);
    int cnt [2];
    int bad_ack, bad_rd;
    bit any;
    cnt[0] = 0; cnt[1] = 0; bad_ack = 0; bad_rd = 0;
    for (int i = 0; i < 1200; i++) begin
      @(negedge clk);
      any = 1'b0;
      for (int d = 0; d < 2; d++) begin
        if (m[d]) begin
          if (busy[d]) begin cnt[d]++; any = 1'b1; end
          if (busy[d] && ack[d]) bad_ack++;
          if (busy[d] && rdata[d] != 32'h0) bad_rd++;
        end
      end
      if (!any) break;
    end
    for (int d = 0; d < 2; d++) begin
      if (m[d]) check($sformatf("dut%0d_sweep_busy_cycles", d), 32'(cnt[d]), 32'd1024);
    end
    check("sweep_ack_low", 32'(bad_ack), 32'd0);
    check("sweep_rdata_zero", 32'(bad_rd), 32'd0);
  endtask

  initial begin
    int a1, a2, a3, t0, t1, tmp, n;
    rst = 2'b11; req = 2'b00;
    for (int d = 0; d < 2; d++) begin
      addr[d] = '0; wdata[d] = '0; wbe[d] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 2'b00;
    sweep(2'b11);
    sweep_done0 = 1'b1;
    @(posedge clk);
    #1;

    // Zero-wait instance: clear check, read-first, partial lanes, back-to-back
    issue(0, 10'h3FF, 32'h0,        4'h0, 32'h00000000, 1'b1, tmp);
    issue(0, 10'd5,   32'hDEADBEEF, 4'hF, 32'h00000000, 1'b1, tmp);
    issue(0, 10'd5,   32'h0,        4'h0, 32'hDEADBEEF, 1'b1, tmp);
    issue(0, 10'd5,   32'hAAAAAAAA, 4'h4, 32'hDEADBEEF, 1'b1, tmp);
    issue(0, 10'd5,   32'h11111111, 4'h1, 32'hDEAABEEF, 1'b1, tmp);
    issue(0, 10'd5,   32'h0,        4'h0, 32'hDEAABE11, 1'b1, tmp);
    issue(0, 10'd6,   32'h12345678, 4'h5, 32'h00000000, 1'b1, tmp);
    issue(0, 10'd6,   32'h0,        4'h0, 32'h00340078, 1'b1, tmp);
    issue(0, 10'd1,   32'h1,        4'hF, 32'h00000000, 1'b1, tmp);
    issue(0, 10'd2,   32'h2,        4'hF, 32'h00000000, 1'b1, tmp);
    issue(0, 10'd3,   32'h3,        4'hF, 32'h00000000, 1'b1, tmp);
    issue(0, 10'd1,   32'h0,        4'h0, 32'h00000001, 1'b1, a1);
    issue(0, 10'd2,   32'h0,        4'h0, 32'h00000002, 1'b1, a2);
    issue(0, 10'd3,   32'h0,        4'h0, 32'h00000003, 1'b1, a3);
    idle(0);
    check("dut0_b2b_accept_2", 32'(a2 - a1), 32'd1);
    check("dut0_b2b_accept_3", 32'(a3 - a2), 32'd1);

    // Three-wait instance: second request waits out the busy window
    issue(1, 10'd9, 32'hCAFEF00D, 4'hF, 32'h00000000, 1'b1, t0);
    issue(1, 10'd9, 32'h0,        4'h0, 32'hCAFEF00D, 1'b1, t1);
    idle(1);
    check("dut1_second_accept_delay", 32'(t1 - t0), 32'd4);
    repeat (6) @(posedge clk);
    #1;

    // Reset while the write to addr 7 is in WAIT: no ack, write swept away
    issue(1, 10'd7, 32'h12345678, 4'hF, 32'h0, 1'b0, tmp);
    idle(1);
    check("dut1_in_wait_busy", 32'(busy[1]), 32'd1);
    rst[1] = 1'b1;
    @(posedge clk);
    #1;
    rst[1] = 1'b0;
    sweep(2'b10);
    @(posedge clk);
    #1;
    issue(1, 10'd7, 32'h0, 4'h0, 32'h00000000, 1'b1, tmp);
    idle(1);

    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 100) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    check("dut0_queue_drained", 32'(q0.size()), 32'd0);
    check("dut1_queue_drained", 32'(q1.size()), 32'd0);
    check("dut0_busy_outside_clear", 32'(busy0_viol), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
